// File: rtl/pend_wr_pkg.sv
// Shared types and constants for the pending-write scheduler.
package pend_wr_pkg;

  // Default widths. The entry struct below is built from these widths.
  localparam int PW_ADDR_W   = 64;
  localparam int PW_DATA_W   = 64;
  localparam int PW_SIZE_W   = 4;

  // Load/store aliasing is checked at doubleword granularity.
  localparam int DWORD_SHIFT = 3;

  // One buffered write as committed at writeback.
  typedef struct packed {
    logic [PW_ADDR_W-1:0] addr;
    logic [PW_DATA_W-1:0] value;
    logic [PW_SIZE_W-1:0] size;
  } pend_wr_t;

  // Drain FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } pws_state_t;

  // True when two addresses fall in the same aligned doubleword.
  function automatic logic same_dword(input logic [PW_ADDR_W-1:0] a,
                                      input logic [PW_ADDR_W-1:0] b);
    return a[PW_ADDR_W-1:DWORD_SHIFT] == b[PW_ADDR_W-1:DWORD_SHIFT];
  endfunction

endpackage

// File: rtl/pend_wr_fifo.sv
// In-order storage for pending writes: circular buffer with read/write
// pointers, an occupancy count and a per-entry valid bit. All entries are
// exported so the top can compare every queued write against a load.
module pend_wr_fifo
  import pend_wr_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,       // synchronous, active-low
  input  logic             push_i,      // caller guarantees !full_o
  input  pend_wr_t         push_data_i,
  input  logic             pop_i,       // ignored when empty
  output pend_wr_t         head_o,
  output pend_wr_t         entries_o [DEPTH],
  output logic [DEPTH-1:0] valid_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  pend_wr_t         mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  logic do_push;
  logic do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

  // A full queue never accepts, an empty one never pops.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next-state for pointers, count and valid bits; pointers wrap
  // naturally because DEPTH is a power of two.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (do_pop) begin
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
      valid_d[rd_ptr_q] = 1'b0;
    end
    if (do_push) begin
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      valid_d[wr_ptr_q] = 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset empties the queue.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload storage; contents are qualified by valid_q so need no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = valid_q;
  assign count_o = count_q;

  // Export every slot for the aliasing check.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_o[i] = mem_q[i];
    end
  end

endmodule

// File: rtl/pend_write_sched.sv
// Pending-write scheduler. Buffers writes committed at writeback and drains
// them in order to the data-memory write port, one outstanding at a time.
//
// Memory handshake: mem_req_valid is held high with a stable payload (the
// queue head) until a cycle where mem_req_ready is also high; that cycle is
// the acceptance. The write then stays queued (and visible to ld_hazard)
// until memory pulses mem_wr_done, which pops it. mem_wr_done is ignored
// unless a write is in flight.
module pend_write_sched
  import pend_wr_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = PW_ADDR_W,
  parameter int DATA_W = PW_DATA_W,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,          // synchronous, active-low
  input  logic              icachenotstall,
  input  logic              enq_valid,
  input  logic [ADDR_W-1:0] enq_addr,
  input  logic [DATA_W-1:0] enq_value,
  input  logic [3:0]        enq_size,
  output logic              full_stall,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_value,
  output logic [3:0]        mem_req_size,
  input  logic              mem_req_ready,
  input  logic              mem_wr_done,
  input  logic [ADDR_W-1:0] ld_chk_addr,
  output logic              ld_hazard,
  output logic              ecall_ready,
  output logic              overflow,
  output pws_state_t        dbg_state,      // drain FSM state
  output logic [CNT_W-1:0]  dbg_count       // queue occupancy
);

  pws_state_t       state_q;
  logic             req_valid_q;
  logic             overflow_q;

  pend_wr_t         push_data;
  pend_wr_t         head;
  pend_wr_t         entries [DEPTH];
  logic [DEPTH-1:0] entry_valid;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             enq_attempt;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count_after_pop;
  logic             hazard;
  logic             unused_ok;

  assign enq_attempt = enq_valid && icachenotstall;
  assign push        = enq_attempt && !fifo_full;
  assign pop         = (state_q == WAIT) && mem_wr_done;

  assign push_data.addr  = PW_ADDR_W'(enq_addr);
  assign push_data.value = PW_DATA_W'(enq_value);
  assign push_data.size  = enq_size;

  pend_wr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .entries_o   (entries),
    .valid_o     (entry_valid),
    .count_o     (count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Occupancy once the in-flight write retires, counting a same-cycle push.
  assign count_after_pop = count - CNT_W'(1) + CNT_W'(push);

  // Drain FSM with registered request-valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q     <= ISSUE;
            req_valid_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            state_q     <= WAIT;
            req_valid_q <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_wr_done) begin
            if (count_after_pop != '0) begin
              state_q     <= ISSUE;
              req_valid_q <= 1'b1;
            end else begin
              state_q     <= IDLE;
              req_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Sticky record of a write lost to a full queue.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (enq_attempt && fifo_full) begin
      overflow_q <= 1'b1;
    end
  end

  // Conservative doubleword alias check against every queued write,
  // including the one in flight (it stays valid until popped).
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && same_dword(entries[i].addr, PW_ADDR_W'(ld_chk_addr))) begin
        hazard = 1'b1;
      end
    end
  end

  assign full_stall    = fifo_full;
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = ADDR_W'(head.addr);
  assign mem_req_value = DATA_W'(head.value);
  assign mem_req_size  = head.size;
  assign ld_hazard     = hazard;
  assign ecall_ready   = fifo_empty && (state_q == IDLE);
  assign overflow      = overflow_q;
  assign dbg_state     = state_q;
  assign dbg_count     = count;

  // Byte-offset bits of the load address do not take part in the check.
  assign unused_ok = ^ld_chk_addr[DWORD_SHIFT-1:0];

endmodule

// File: tb/tb_pend_write_sched.sv
// Directed bench for pend_write_sched: inputs change on the falling edge,
// outputs are checked 1ns later, well away from the rising edge.
module tb_pend_write_sched;
  import pend_wr_pkg::*;

  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk;
  logic              reset;
  logic              icachenotstall;
  logic              enq_valid;
  logic [63:0]       enq_addr;
  logic [63:0]       enq_value;
  logic [3:0]        enq_size;
  logic              full_stall;
  logic              mem_req_valid;
  logic [63:0]       mem_req_addr;
  logic [63:0]       mem_req_value;
  logic [3:0]        mem_req_size;
  logic              mem_req_ready;
  logic              mem_wr_done;
  logic [63:0]       ld_chk_addr;
  logic              ld_hazard;
  logic              ecall_ready;
  logic              overflow;
  pws_state_t        dbg_state;
  logic [CNT_W-1:0]  dbg_count;

  int n_cmp = 0;
  int n_err = 0;

  pend_write_sched #(
    .DEPTH (DEPTH), .ADDR_W (64), .DATA_W (64)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .icachenotstall (icachenotstall),
    .enq_valid      (enq_valid),
    .enq_addr       (enq_addr),
    .enq_value      (enq_value),
    .enq_size       (enq_size),
    .full_stall     (full_stall),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_value  (mem_req_value),
    .mem_req_size   (mem_req_size),
    .mem_req_ready  (mem_req_ready),
    .mem_wr_done    (mem_wr_done),
    .ld_chk_addr    (ld_chk_addr),
    .ld_hazard      (ld_hazard),
    .ecall_ready    (ecall_ready),
    .overflow       (overflow),
    .dbg_state      (dbg_state),
    .dbg_count      (dbg_count)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    icachenotstall = 1'b1;
    enq_valid      = 1'b0;
    enq_addr       = '0;
    enq_value      = '0;
    enq_size       = '0;
    mem_req_ready  = 1'b0;
    mem_wr_done    = 1'b0;
    ld_chk_addr    = '0;
    tick();
    reset = 1'b1;
  endtask

  // Present one write for exactly one rising edge.
  task automatic enq(input logic [63:0] a, input logic [63:0] v, input logic [3:0] s);
    enq_valid = 1'b1;
    enq_addr  = a;
    enq_value = v;
    enq_size  = s;
    tick();
    enq_valid = 1'b0;
  endtask

  initial begin
    @(negedge clk);

    // ---- 1: reset then idle
    do_reset();
    tick();
    #1;
    chk("t1_req_valid", mem_req_valid, 0);
    chk("t1_ecall",     ecall_ready, 1);
    chk("t1_full",      full_stall, 0);
    chk("t1_overflow",  overflow, 0);
    chk("t1_hazard",    ld_hazard, 0);

    // ---- 2: single write, full handshake
    enq(64'h1000, 64'hDEAD, 4'd8);
    #1;
    chk("t2_cnt_after_enq",   dbg_count, 1);
    chk("t2_valid_n",         mem_req_valid, 0);
    chk("t2_ecall_busy",      ecall_ready, 0);
    tick();
    #1;
    chk("t2_valid_n1",        mem_req_valid, 1);
    chk("t2_addr",            mem_req_addr, 64'h1000);
    chk("t2_value",           mem_req_value, 64'hDEAD);
    chk("t2_size",            mem_req_size, 8);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #1;
    chk("t2_valid_wait",      mem_req_valid, 0);
    chk("t2_state_wait",      dbg_state, WAIT);
    chk("t2_ecall_wait",      ecall_ready, 0);
    mem_wr_done = 1'b1;
    tick();
    mem_wr_done = 1'b0;
    #1;
    chk("t2_cnt_done",        dbg_count, 0);
    chk("t2_ecall_done",      ecall_ready, 1);
    tick();
    #1;
    chk("t2_ecall_later",     ecall_ready, 1);
    chk("t2_valid_later",     mem_req_valid, 0);

    // ---- 3: five writes into a four-deep queue, memory not ready
    do_reset();
    for (int i = 0; i < 3; i++) enq(64'h3000 + 64'(8 * i), 64'h30 + 64'(i), 4'd4);
    #1;
    chk("t3_full_after3",     full_stall, 0);
    enq(64'h3018, 64'h33, 4'd4);
    #1;
    chk("t3_full_after4",     full_stall, 1);
    chk("t3_ovf_after4",      overflow, 0);
    enq(64'h3020, 64'h34, 4'd4);
    #1;
    chk("t3_ovf_after5",      overflow, 1);
    chk("t3_cnt_after5",      dbg_count, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_req_valid",     mem_req_valid, 1);
      chk("t3_req_addr",      mem_req_addr, 64'h3000 + 64'(8 * i));
      chk("t3_req_value",     mem_req_value, 64'h30 + 64'(i));
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      #1;
      chk("t3_wait_valid",    mem_req_valid, 0);
      mem_wr_done = 1'b1;
      tick();
      mem_wr_done = 1'b0;
      #1;
    end
    chk("t3_drained_valid",   mem_req_valid, 0);
    chk("t3_drained_ecall",   ecall_ready, 1);
    chk("t3_drained_full",    full_stall, 0);
    tick();
    #1;
    chk("t3_no_fifth",        mem_req_valid, 0);
    chk("t3_ovf_sticky",      overflow, 1);

    // ---- 4: load aliasing against an in-flight write
    do_reset();
    ld_chk_addr = 64'h2008;
    enq_valid = 1'b1;
    enq_addr  = 64'h2008;
    enq_value = 64'h44;
    enq_size  = 4'd8;
    #1;
    chk("t4_same_cycle_enq",  ld_hazard, 0);
    tick();
    enq_valid = 1'b0;
    #1;
    chk("t4_queued",          ld_hazard, 1);
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #1;
    chk("t4_state_wait",      dbg_state, WAIT);
    ld_chk_addr = 64'h200C;
    #1;
    chk("t4_200c_inflight",   ld_hazard, 1);
    ld_chk_addr = 64'h2010;
    #1;
    chk("t4_2010",            ld_hazard, 0);
    ld_chk_addr = 64'h2000;
    #1;
    chk("t4_2000",            ld_hazard, 0);
    // pipeline stalled: no enqueue
    icachenotstall = 1'b0;
    enq_valid = 1'b1;
    enq_addr  = 64'h2200;
    tick();
    icachenotstall = 1'b1;
    enq_valid = 1'b0;
    #1;
    chk("t4_stall_no_enq",    dbg_count, 1);
    // enqueue and pop in the same cycle
    enq_valid = 1'b1;
    enq_addr  = 64'h2100;
    enq_value = 64'h55;
    mem_wr_done = 1'b1;
    tick();
    enq_valid = 1'b0;
    mem_wr_done = 1'b0;
    #1;
    chk("t4_cnt_enq_pop",     dbg_count, 1);
    chk("t4_state_issue",     dbg_state, ISSUE);
    chk("t4_head_next",       mem_req_addr, 64'h2100);
    ld_chk_addr = 64'h200C;
    #1;
    chk("t4_200c_popped",     ld_hazard, 0);
    ld_chk_addr = 64'h2104;
    #1;
    chk("t4_2104_new",        ld_hazard, 1);

    // ---- 5: full queue, enqueue and completion in the same cycle
    do_reset();
    for (int i = 0; i < 4; i++) enq(64'h4000 + 64'(8 * i), 64'h40 + 64'(i), 4'd2);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #1;
    chk("t5_full_wait",       full_stall, 1);
    enq_valid = 1'b1;
    enq_addr  = 64'h5000;
    enq_value = 64'h50;
    mem_wr_done = 1'b1;
    tick();
    enq_valid = 1'b0;
    mem_wr_done = 1'b0;
    ld_chk_addr = 64'h5000;
    #1;
    chk("t5_overflow",        overflow, 1);
    chk("t5_cnt",             dbg_count, 3);
    chk("t5_full_cleared",    full_stall, 0);
    chk("t5_state_issue",     dbg_state, ISSUE);
    chk("t5_head",            mem_req_addr, 64'h4008);
    chk("t5_size",            mem_req_size, 2);
    chk("t5_dropped_no_haz",  ld_hazard, 0);

    // ---- 6: reset while a write is in flight
    do_reset();
    for (int i = 0; i < 3; i++) enq(64'h6000 + 64'(8 * i), 64'h60 + 64'(i), 4'd1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #1;
    chk("t6_pre_state",       dbg_state, WAIT);
    chk("t6_pre_cnt",         dbg_count, 3);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("t6_cnt",             dbg_count, 0);
    chk("t6_state",           dbg_state, IDLE);
    chk("t6_ecall",           ecall_ready, 1);
    chk("t6_valid",           mem_req_valid, 0);
    ld_chk_addr = 64'h6000;
    #1;
    chk("t6_hazard",          ld_hazard, 0);
    mem_wr_done = 1'b1;
    tick();
    mem_wr_done = 1'b0;
    #1;
    chk("t6_late_done_cnt",   dbg_count, 0);
    chk("t6_late_done_state", dbg_state, IDLE);
    // completion while IDLE with a queued write must not pop it
    enq(64'h7000, 64'h70, 4'd8);
    mem_wr_done = 1'b1;
    tick();
    mem_wr_done = 1'b0;
    #1;
    chk("t6_idle_done_cnt",   dbg_count, 1);
    chk("t6_idle_done_state", dbg_state, ISSUE);
    chk("t6_idle_done_addr",  mem_req_addr, 64'h7000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
